// File: rtl/switch_bank_pkg.sv
// -----------------------------------------------------------------------------
// switch_bank_pkg
// Shared constants and helpers for the switch_toggle_bank block.
//   TOGGLE_ON_RELEASE / TOGGLE_ON_PRESS : values accepted by the top-level
//                                         TOGGLE_ON_PRESS parameter
//   cnt_width(limit)                    : bits needed to hold 0..limit
// -----------------------------------------------------------------------------
package switch_bank_pkg;

    localparam int TOGGLE_ON_RELEASE = 0;
    localparam int TOGGLE_ON_PRESS   = 1;

    function automatic int cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/switch_toggle_bank_debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One switch bit: two-flop synchroniser followed by a debounce counter that
// only accepts a new level after it has been seen continuously for
// DEBOUNCE_LIMIT cycles.
// Ports:
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset
//   raw   : raw switch pin, asynchronous to clk
//   level : debounced level
// -----------------------------------------------------------------------------
module debounce_channel
    import switch_bank_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = cnt_width(DEBOUNCE_LIMIT);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            count   <= '0;
            level   <= 1'b0;
        end else begin
            // synchroniser stages; only sync_p1 is safe to use below
            sync_p0 <= raw;
            sync_p1 <= sync_p0;

            // any sample agreeing with the current level restarts the count
            if (sync_p1 == level) begin
                count <= '0;
            end else if (count == CNT_W'(DEBOUNCE_LIMIT - 1)) begin
                level <= sync_p1;
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/switch_toggle_bank.sv
// -----------------------------------------------------------------------------
// switch_toggle_bank
// NUM_CH independent push-button channels: synchronise, debounce, detect
// press/release edges and drive a per-channel toggle register.
// Optional feature macro: SWITCH_TOGGLE_HOLD_EN adds long-hold detection that
// pulses o_Hold and clears the channel's toggle state.
// Ports:
//   i_Clk     : system clock, rising edge
//   i_Rst     : asynchronous active-high reset
//   i_Switch  : raw switch pins (pressed = 1)
//   o_Level   : debounced levels
//   o_Press   : one-cycle pulse on debounced 0->1
//   o_Release : one-cycle pulse on debounced 1->0
//   o_Toggle  : per-channel toggle state
//   o_Hold    : one-cycle pulse when a long hold is reached (0 without macro)
// -----------------------------------------------------------------------------
module switch_toggle_bank
    import switch_bank_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_LIMIT  = 250000,
    parameter int TOGGLE_ON_PRESS = 0,
    parameter int HOLD_LIMIT      = 25000000
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [NUM_CH-1:0] i_Switch,
    output logic [NUM_CH-1:0] o_Level,
    output logic [NUM_CH-1:0] o_Press,
    output logic [NUM_CH-1:0] o_Release,
    output logic [NUM_CH-1:0] o_Toggle,
    output logic [NUM_CH-1:0] o_Hold
);

    localparam bit PRESS_MODE = (TOGGLE_ON_PRESS == switch_bank_pkg::TOGGLE_ON_PRESS);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
        ) u_debounce (
            .clk   (i_Clk),
            .rst   (i_Rst),
            .raw   (i_Switch[g]),
            .level (o_Level[g])
        );
    end

    logic [NUM_CH-1:0] level_prev;
    logic [NUM_CH-1:0] press_next;
    logic [NUM_CH-1:0] release_next;
    logic [NUM_CH-1:0] toggle_event;
    logic [NUM_CH-1:0] toggle_next;

    assign press_next   = o_Level & ~level_prev;
    assign release_next = ~o_Level & level_prev;
    assign toggle_event = PRESS_MODE ? press_next : release_next;

`ifdef SWITCH_TOGGLE_HOLD_EN
    localparam int HOLD_W = cnt_width(HOLD_LIMIT);

    logic [HOLD_W-1:0] hold_cnt [NUM_CH];
    logic [NUM_CH-1:0] hold_next;
    logic [NUM_CH-1:0] held;
    logic [NUM_CH-1:0] suppress;

    // fires on the edge where the counter steps into its saturated value
    always_comb begin
        hold_next = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            hold_next[c] = o_Level[c] && (hold_cnt[c] == HOLD_W'(HOLD_LIMIT - 2));
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                hold_cnt[c] <= '0;
            end
            held   <= '0;
            o_Hold <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!o_Level[c]) begin
                    hold_cnt[c] <= '0;
                end else if (hold_cnt[c] != HOLD_W'(HOLD_LIMIT - 1)) begin
                    hold_cnt[c] <= hold_cnt[c] + HOLD_W'(1);
                end
            end
            // remembers a completed hold until its release has been consumed
            held   <= (held | hold_next) & ~release_next;
            o_Hold <= hold_next;
        end
    end

    // a release ending a long hold must not toggle the channel back on
    assign suppress    = PRESS_MODE ? '0 : held;
    assign toggle_next = (o_Toggle ^ (toggle_event & ~suppress)) & ~hold_next;
`else
    assign o_Hold      = '0;
    assign toggle_next = o_Toggle ^ toggle_event;
`endif

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            level_prev <= '0;
            o_Press    <= '0;
            o_Release  <= '0;
            o_Toggle   <= '0;
        end else begin
            level_prev <= o_Level;
            o_Press    <= press_next;
            o_Release  <= release_next;
            o_Toggle   <= toggle_next;
        end
    end

endmodule
